// File: rtl/burst_pkg.sv
// Shared types and default widths for the burst loopback slave.
// The read FSM state encoding lives here so the bench and the RTL agree on it.
package burst_pkg;

    localparam int unsigned BURST_DATA_W = 32;
    localparam int unsigned BURST_LEN_W  = 8;
    localparam int unsigned BURST_DEPTH  = 16;

    typedef logic [BURST_DATA_W-1:0] beat_t;

    typedef enum logic [0:0] {
        RD_IDLE,
        RD_STREAM
    } rd_state_t;

endpackage

// File: rtl/burst_sync_fifo.sv
// Single-clock circular buffer with wrap-bit pointers and a registered occupancy count.
// full/empty come only from registered state, so a pop never frees space in the same cycle.
module burst_sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic [AW:0]       level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + ONE;
            case ({push, pop})
                2'b10:   level_q <= level_q + ONE;
                2'b01:   level_q <= level_q - ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage has no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/burst_loopback_slave.sv
// Burst peer for the APB-to-burst bridge: buffers write bursts and replays them as read bursts.
// Read bursts stall on an empty buffer rather than truncating.
module burst_loopback_slave
    import burst_pkg::*;
#(
    parameter int unsigned DATA_W = BURST_DATA_W,
    parameter int unsigned DEPTH  = BURST_DEPTH,
    parameter int unsigned LEN_W  = BURST_LEN_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       burst_valid,
    output logic                       burst_ready,
    input  logic [DATA_W-1:0]          data_burst_out,
    input  logic                       burst_last,
    input  logic                       rd_req,
    input  logic [LEN_W-1:0]           db_length,
    output logic                       db_valid,
    input  logic                       db_ready,
    output logic [DATA_W-1:0]          data_burst_in,
    output logic                       last,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                wr_bursts,
    output logic                       rd_busy,
    output logic                       req_err
);

    rd_state_t         state_q, state_d;
    logic [LEN_W-1:0]  beats_q, beats_d;
    logic [15:0]       wr_bursts_q;
    logic              req_err_q;
    logic              push, pop, full, empty;
    logic [DATA_W-1:0] rdata;

    assign burst_ready = !full;
    assign push        = burst_valid && burst_ready;

    burst_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (data_burst_out),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            beats_q     <= '0;
            wr_bursts_q <= '0;
            req_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            beats_q   <= beats_d;
            req_err_q <= rd_req && (rd_busy || db_length == '0);
            if (push && burst_last) wr_bursts_q <= wr_bursts_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        unique case (state_q)
            RD_IDLE: begin
                if (rd_req && db_length != '0) begin
                    state_d = RD_STREAM;
                    beats_d = db_length;
                end
            end
            RD_STREAM: begin
                if (pop) begin
                    beats_d = beats_q - LEN_W'(1);
                    if (beats_q == LEN_W'(1)) state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_busy       = (state_q == RD_STREAM);
        db_valid      = rd_busy && !empty;
        last          = db_valid && (beats_q == LEN_W'(1));
        pop           = db_valid && db_ready;
        data_burst_in = db_valid ? rdata : '0;
    end

    assign wr_bursts = wr_bursts_q;
    assign req_err   = req_err_q;

endmodule

// File: tb/tb_burst_loopback_slave.sv
// Directed bench for burst_loopback_slave: reset, streaming, full back-pressure, empty stall,
// rejected requests and mid-burst reset, all against hand-computed values.
module tb_burst_loopback_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        burst_valid;
    logic        burst_ready;
    logic [31:0] data_burst_out;
    logic        burst_last;
    logic        rd_req;
    logic [7:0]  db_length;
    logic        db_valid;
    logic        db_ready;
    logic [31:0] data_burst_in;
    logic        last;
    logic [4:0]  level;
    logic [15:0] wr_bursts;
    logic        rd_busy;
    logic        req_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    burst_loopback_slave dut (
        .clk            (clk),
        .rst            (rst),
        .burst_valid    (burst_valid),
        .burst_ready    (burst_ready),
        .data_burst_out (data_burst_out),
        .burst_last     (burst_last),
        .rd_req         (rd_req),
        .db_length      (db_length),
        .db_valid       (db_valid),
        .db_ready       (db_ready),
        .data_burst_in  (data_burst_in),
        .last           (last),
        .level          (level),
        .wr_bursts      (wr_bursts),
        .rd_busy        (rd_busy),
        .req_err        (req_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [31:0] d, input logic l);
        int n = 0;
        burst_valid    = 1'b1;
        data_burst_out = d;
        burst_last     = l;
        while (!burst_ready && n < 50) begin
            step();
            n++;
        end
        if (!burst_ready) check("push_timeout", {31'd0, burst_ready}, 32'd1);
        step();
        burst_valid = 1'b0;
        burst_last  = 1'b0;
    endtask

    task automatic start_read(input logic [7:0] len);
        rd_req    = 1'b1;
        db_length = len;
        step();
        rd_req    = 1'b0;
        db_length = '0;
    endtask

    task automatic pop_beat(input string tag, input logic [31:0] exp, input logic exp_last);
        int n = 0;
        db_ready = 1'b1;
        while (!db_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_data"}, data_burst_in, exp);
        check({tag, "_last"}, {31'd0, last}, {31'd0, exp_last});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; burst_valid = 1'b0; data_burst_out = '0; burst_last = 1'b0;
        rd_req = 1'b0; db_length = '0; db_ready = 1'b0;

        // 1: reset
        step();
        step();
        rst = 1'b0;
        check("rst_level", {27'd0, level}, 32'd0);
        check("rst_db_valid", {31'd0, db_valid}, 32'd0);
        check("rst_wr_bursts", {16'd0, wr_bursts}, 32'd0);
        check("rst_burst_ready", {31'd0, burst_ready}, 32'd1);
        check("rst_rd_busy", {31'd0, rd_busy}, 32'd0);
        check("rst_req_err", {31'd0, req_err}, 32'd0);

        // 2: write 4, read 4 back-to-back
        for (int i = 0; i < 4; i++) push_beat(32'hA0 + i, i == 3);
        check("t2_level", {27'd0, level}, 32'd4);
        check("t2_wr_bursts", {16'd0, wr_bursts}, 32'd1);
        db_ready = 1'b1;
        start_read(8'd4);
        for (int i = 0; i < 4; i++) begin
            check("t2_valid", {31'd0, db_valid}, 32'd1);
            check("t2_data", data_burst_in, 32'hA0 + i);
            check("t2_last", {31'd0, last}, (i == 3) ? 32'd1 : 32'd0);
            step();
        end
        check("t2_idle", {31'd0, rd_busy}, 32'd0);
        check("t2_empty_level", {27'd0, level}, 32'd0);
        check("t2_valid_off", {31'd0, db_valid}, 32'd0);

        // 3: fill to DEPTH, 17th beat held until one pop
        db_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_beat(32'h100 + i, i == 15);
        check("t3_level_full", {27'd0, level}, 32'd16);
        check("t3_ready_full", {31'd0, burst_ready}, 32'd0);
        burst_valid = 1'b1; data_burst_out = 32'h1FF; burst_last = 1'b0;
        step();
        step();
        check("t3_held_level", {27'd0, level}, 32'd16);
        check("t3_held_ready", {31'd0, burst_ready}, 32'd0);
        db_ready = 1'b1;
        rd_req = 1'b1; db_length = 8'd1;
        step();
        rd_req = 1'b0; db_length = '0;
        check("t3_pop_data", data_burst_in, 32'h100);
        check("t3_ready_at_pop", {31'd0, burst_ready}, 32'd0);
        step();
        check("t3_ready_after_pop", {31'd0, burst_ready}, 32'd1);
        check("t3_level_after_pop", {27'd0, level}, 32'd15);
        step();
        burst_valid = 1'b0;
        check("t3_level_refill", {27'd0, level}, 32'd16);
        check("t3_wr_bursts", {16'd0, wr_bursts}, 32'd2);
        start_read(8'd16);
        for (int i = 0; i < 15; i++) pop_beat("t3_drain", 32'h101 + i, 1'b0);
        pop_beat("t3_drain17", 32'h1FF, 1'b1);
        check("t3_drained", {27'd0, level}, 32'd0);
        check("t3_idle", {31'd0, rd_busy}, 32'd0);

        // 4: burst stalls on empty, resumes, never truncated
        db_ready = 1'b0;
        push_beat(32'hC0, 1'b0);
        start_read(8'd3);
        pop_beat("t4_b0", 32'hC0, 1'b0);
        db_ready = 1'b0;
        check("t4_gap_valid", {31'd0, db_valid}, 32'd0);
        check("t4_gap_busy", {31'd0, rd_busy}, 32'd1);
        step();
        check("t4_gap_valid2", {31'd0, db_valid}, 32'd0);
        push_beat(32'hC1, 1'b0);
        push_beat(32'hC2, 1'b1);
        check("t4_hold_data", data_burst_in, 32'hC1);
        step();
        check("t4_hold_valid", {31'd0, db_valid}, 32'd1);
        check("t4_hold_data2", data_burst_in, 32'hC1);
        pop_beat("t4_b1", 32'hC1, 1'b0);
        pop_beat("t4_b2", 32'hC2, 1'b1);
        check("t4_idle", {31'd0, rd_busy}, 32'd0);
        check("t4_wr_bursts", {16'd0, wr_bursts}, 32'd3);

        // 5: rejected requests
        db_ready = 1'b0;
        push_beat(32'hD0, 1'b0);
        push_beat(32'hD1, 1'b1);
        start_read(8'd2);
        check("t5_no_err_ok", {31'd0, req_err}, 32'd0);
        start_read(8'd5);
        check("t5_err_busy", {31'd0, req_err}, 32'd1);
        check("t5_still_busy", {31'd0, rd_busy}, 32'd1);
        step();
        check("t5_err_pulse", {31'd0, req_err}, 32'd0);
        pop_beat("t5_b0", 32'hD0, 1'b0);
        pop_beat("t5_b1", 32'hD1, 1'b1);
        check("t5_idle", {31'd0, rd_busy}, 32'd0);
        start_read(8'd0);
        check("t5_err_len0", {31'd0, req_err}, 32'd1);
        check("t5_len0_idle", {31'd0, rd_busy}, 32'd0);
        step();
        check("t5_err_len0_pulse", {31'd0, req_err}, 32'd0);

        // 6: reset mid-read, then fresh traffic
        db_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_beat(32'hE0 + i, i == 7);
        start_read(8'd8);
        pop_beat("t6_b0", 32'hE0, 1'b0);
        check("t6_b1_data", data_burst_in, 32'hE1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_valid", {31'd0, db_valid}, 32'd0);
        check("t6_rst_level", {27'd0, level}, 32'd0);
        check("t6_rst_busy", {31'd0, rd_busy}, 32'd0);
        check("t6_rst_wr_bursts", {16'd0, wr_bursts}, 32'd0);
        db_ready = 1'b0;
        push_beat(32'hF0, 1'b0);
        push_beat(32'hF1, 1'b1);
        start_read(8'd2);
        pop_beat("t6_f0", 32'hF0, 1'b0);
        pop_beat("t6_f1", 32'hF1, 1'b1);
        check("t6_wr_bursts", {16'd0, wr_bursts}, 32'd1);
        check("t6_level", {27'd0, level}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
